pll_lock_monitor: RTL
=====================

Name: pll_lock_monitor

Overview:
Downstream companion to the PLL primitive. It runs on the PLL output clock and consumes the asynchronous PLL LOCK signal. It synchronizes and qualifies LOCK, then sequences a reset/ready pair for downstream fabric logic. It also filters short lock glitches and counts genuine lock-loss events.

Parameters:
SYNC_STAGES, 2, number of LOCK synchronizer flops (legal range 2-4).
SETTLE_CYCLES, 256, consecutive synchronized-lock-high cycles required before leaving reset (legal range 1-65535).
HOLDOFF_CYCLES, 16, cycles between RESET_OUT deassertion and READY assertion (legal range 0-255).
GLITCH_FILTER, 4, consecutive synchronized-lock-low cycles in RUN that count as a loss (legal range 1-255).
LOSS_CNT_WIDTH, 8, width of LOSS_COUNT.
TIMEOUT_CYCLES, 100000, lock-acquire watchdog limit (used only with the optional feature).

Ports:
CLK  input  1  PLL output clock (CLK_OUT or FAST_CLK domain).
RESET  input  1  asynchronous, active-high reset.
ENABLE  input  1  monitor enable; normally tied to the same source as PLL_EN.
LOCK  input  1  PLL LOCK, asynchronous to CLK.
RESET_OUT  output  1  reset for downstream logic; asserts asynchronously, deasserts synchronously.
READY  output  1  downstream clock domain valid.
LOSS_COUNT  output  LOSS_CNT_WIDTH  saturating count of lock losses.
LOCK_TIMEOUT  output  1  sticky watchdog flag.

Behaviour:
Clock and reset: one clock, CLK. Reset is asynchronous and active-high, on port RESET.
Reset values: state=IDLE, RESET_OUT=1, READY=0, LOSS_COUNT=0, LOCK_TIMEOUT=0, all counters 0, synchronizer flops 0.
Synchronizer: LOCK passes through SYNC_STAGES flops; lock_s is the last flop. No other logic reads LOCK.
All outputs are registered.
FSM states: IDLE, WAIT_LOCK, SETTLE, RUN, LOST.
- IDLE -> WAIT_LOCK when ENABLE=1.
- WAIT_LOCK -> SETTLE when lock_s=1. Settle counter is cleared.
- SETTLE: the counter increments each cycle lock_s=1.
  - lock_s=0 -> WAIT_LOCK and the counter clears. No filtering in this state.
  - lock_s=1 with counter = SETTLE_CYCLES-1 -> RUN.
- RUN: RESET_OUT=0 from the RUN entry edge. The holdoff counter counts HOLDOFF_CYCLES, then READY=1. HOLDOFF_CYCLES=0 means READY rises on the same edge as RESET_OUT falls.
- RUN loss filter: a counter of consecutive lock_s=0 cycles, cleared by any lock_s=1. When it reaches GLITCH_FILTER -> LOST.
- LOST: RESET_OUT=1 and READY=0 from the entry edge. LOSS_COUNT increments once and saturates at all-ones. The next edge goes unconditionally to WAIT_LOCK.
- ENABLE=0 in any state: next edge -> IDLE, RESET_OUT=1, READY=0, no LOSS_COUNT increment. This takes priority over every other transition, including a filter expiry in the same cycle.
Latency: LOCK first sampled high at edge e, with LOCK stable and ENABLE=1 in WAIT_LOCK:
- SETTLE is entered at edge e+SYNC_STAGES.
- RESET_OUT falls at edge e+SYNC_STAGES+SETTLE_CYCLES.
- READY rises at edge e+SYNC_STAGES+SETTLE_CYCLES+HOLDOFF_CYCLES.
Loss latency: lock_s low first at edge f -> READY/RESET_OUT change at edge f+GLITCH_FILTER.
Invariant: READY=1 implies RESET_OUT=0.
RESET mid-operation: all state returns to reset values immediately and LOSS_COUNT clears. LOSS_COUNT clears only on RESET.

Optional Feature:
Macro: PLL_LOCK_MON_TIMEOUT_EN.
Defined:
- A watchdog counter runs while the state is WAIT_LOCK or SETTLE. It clears on entry to IDLE or RUN and does not clear on SETTLE->WAIT_LOCK.
- When the counter reaches TIMEOUT_CYCLES, LOCK_TIMEOUT is set.
- LOCK_TIMEOUT is sticky until RESET or ENABLE=0.
- The FSM is unaffected.
Undefined: no counter logic exists and LOCK_TIMEOUT is tied to 0.

Test Plan:
Bench parameters: SYNC_STAGES=2, SETTLE_CYCLES=8, HOLDOFF_CYCLES=4, GLITCH_FILTER=4.
1. ENABLE=1, LOCK rises before edge 0 -> RESET_OUT falls at edge 10, READY rises at edge 14, LOSS_COUNT=0.
2. In RUN, LOCK low for 3 cycles then high -> READY stays 1, LOSS_COUNT=0. LOCK low for 4+ cycles -> READY=0 and RESET_OUT=1 at the 4th edge after lock_s falls; LOSS_COUNT=1; state WAIT_LOCK next edge.
3. During SETTLE, LOCK drops for 1 cycle at settle count 5 -> returns to WAIT_LOCK. The full 8-cycle settle restarts, so READY is delayed accordingly.
4. In RUN, ENABLE=0 in the same cycle the loss filter expires -> IDLE, LOSS_COUNT unchanged, RESET_OUT=1.
5. LOSS_CNT_WIDTH=2, force 5 losses -> LOSS_COUNT sticks at 3. Assert RESET mid-SETTLE -> all outputs return to reset values immediately and asynchronously.
6. With PLL_LOCK_MON_TIMEOUT_EN, TIMEOUT_CYCLES=50, LOCK held 0 -> LOCK_TIMEOUT=1 after 50 cycles in WAIT_LOCK, cleared by ENABLE=0. Without the macro, LOCK_TIMEOUT stays 0.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: synchronizes and qualifies the PLL LOCK signal, then
// sequences RESET_OUT / READY for the logic clocked by the PLL output.
// Short lock dropouts while running are filtered; real losses are counted.
// Optional lock-acquire watchdog is built when PLL_LOCK_MON_TIMEOUT_EN is
// defined; otherwise LOCK_TIMEOUT is a constant 0.
module pll_lock_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 256,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int GLITCH_FILTER  = 4,
    parameter int LOSS_CNT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      ENABLE,
    input  logic                      LOCK,
    output logic                      RESET_OUT,
    output logic                      READY,
    output logic [LOSS_CNT_WIDTH-1:0] LOSS_COUNT,
    output logic                      LOCK_TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        SETTLE,
        RUN,
        LOST
    } state_t;

    // Terminal values of the cycle counters (last count before the event fires)
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST   = (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]  GLITCH_LAST = 8'(GLITCH_FILTER - 1);

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [15:0]            settle_cnt;
    logic [7:0]             hold_cnt;
    logic [7:0]             glitch_cnt;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // LOCK is asynchronous to CLK; this shift chain is the only reader of it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK};
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; dropping ENABLE overrides every other transition
    always_comb begin
        next_state = state;
        if (!ENABLE) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = WAIT_LOCK;
                WAIT_LOCK: if (lock_s) next_state = SETTLE;
                SETTLE: begin
                    if (!lock_s)
                        next_state = WAIT_LOCK;
                    else if (settle_cnt == SETTLE_LAST)
                        next_state = RUN;
                end
                RUN:       if (!lock_s && glitch_cnt == GLITCH_LAST) next_state = LOST;
                LOST:      next_state = WAIT_LOCK;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Settle, holdoff and dropout counters; each clears whenever its state is left or entered
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            settle_cnt <= '0;
            hold_cnt   <= '0;
            glitch_cnt <= '0;
        end else begin
            settle_cnt <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + 16'd1 : 16'd0;
            glitch_cnt <= (state == RUN && next_state == RUN && !lock_s) ? glitch_cnt + 8'd1 : 8'd0;
            if (state == RUN && next_state == RUN) begin
                if (hold_cnt != HOLD_LAST)
                    hold_cnt <= hold_cnt + 8'd1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Registered outputs decoded from the upcoming state so they change on the transition edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RESET_OUT <= 1'b1;
            READY     <= 1'b0;
        end else begin
            RESET_OUT <= (next_state != RUN);
            if (next_state != RUN)
                READY <= 1'b0;
            else if (HOLDOFF_CYCLES == 0)
                READY <= 1'b1;
            else if (state == RUN && hold_cnt == HOLD_LAST)
                READY <= 1'b1;
        end
    end

    // Saturating count of filtered lock losses; only RESET clears it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LOSS_COUNT <= '0;
        end else if (state == RUN && next_state == LOST && LOSS_COUNT != '1) begin
            LOSS_COUNT <= LOSS_COUNT + LOSS_CNT_WIDTH'(1);
        end
    end

`ifdef PLL_LOCK_MON_TIMEOUT_EN
    localparam int                WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

    logic [WD_WIDTH-1:0] wd_cnt;
    logic                wd_active;
    logic                timeout_q;

    assign wd_active    = (state == WAIT_LOCK || state == SETTLE);
    assign LOCK_TIMEOUT = timeout_q;

    // Watchdog spans the whole acquire attempt, including SETTLE->WAIT_LOCK retries
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt <= '0;
        end else if (next_state == IDLE || next_state == RUN) begin
            wd_cnt <= '0;
        end else if (wd_active && wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end
    end

    // Sticky timeout flag, released only by RESET or ENABLE low
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timeout_q <= 1'b0;
        end else if (!ENABLE) begin
            timeout_q <= 1'b0;
        end else if (wd_active && next_state != RUN && wd_cnt == WD_LIMIT - WD_WIDTH'(1)) begin
            timeout_q <= 1'b1;
        end
    end
`else
    // No watchdog in this build; the comparison is false for every legal TIMEOUT_CYCLES
    assign LOCK_TIMEOUT = (TIMEOUT_CYCLES < 0);
`endif

endmodule
